// File: rtl/mem_credit_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_credit_arb_pkg
// Shared configuration for the memory-credit arbiter slice.
//   MAXMEMCREDIT    : size of the memory-network credit pool
//   MAXMEMCREDITMSB : MSB of a counter that can hold 0..MAXMEMCREDIT
//   mem_credit_t    : credit counter type
//   log2x()         : index width for N requesters (never less than 1 bit)
// ---------------------------------------------------------------------------
package mem_credit_arb_pkg;

   localparam int MAXMEMCREDIT    = 64;
   localparam int MAXMEMCREDITMSB = $clog2(MAXMEMCREDIT + 1) - 1;

   typedef bit [MAXMEMCREDITMSB:0] mem_credit_t;

   // A two-requester arbiter still needs one index bit, hence the floor of 1.
   function automatic int log2x(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mem_credit_arb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker: returns the first set request at
// or after i_ptr, wrapping from NREQ-1 back to 0.
//   i_req   : request vector
//   i_ptr   : index of the highest-priority requester this cycle
//   o_grant : one-hot grant (all zero when no request is set)
//   o_idx   : encoded index of the granted requester
//   o_any   : at least one request is set
// ---------------------------------------------------------------------------
module rr_arbiter
   import mem_credit_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int SW   = log2x(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [SW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_grant,
   output logic [SW-1:0]   o_idx,
   output logic            o_any
);

   logic [NREQ-1:0] w_hi_req;
   logic            w_hi_any;
   logic [SW-1:0]   w_hi_idx;
   logic            w_lo_any;
   logic [SW-1:0]   w_lo_idx;

   // Requests at or above the pointer form the first search window; if that
   // window is empty the lowest request overall is the wrap-around winner.
   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
         assign w_hi_req[gi] = i_req[gi] && (gi >= int'(i_ptr));
      end
   endgenerate

   // Descending scan so the lowest set index is the last one written.
   always_comb begin
      w_hi_any = 1'b0;
      w_hi_idx = '0;
      w_lo_any = 1'b0;
      w_lo_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (w_hi_req[i]) begin
            w_hi_any = 1'b1;
            w_hi_idx = SW'(i);
         end
         if (i_req[i]) begin
            w_lo_any = 1'b1;
            w_lo_idx = SW'(i);
         end
      end
   end

   assign o_any = w_lo_any;
   assign o_idx = w_hi_any ? w_hi_idx : w_lo_idx;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
         assign o_grant[gi] = w_lo_any && (o_idx == SW'(gi));
      end
   endgenerate

endmodule

// File: rtl/mem_credit_arb.sv
// ---------------------------------------------------------------------------
// mem_credit_arb
// Shares the single memory-controller port among NREQ pipeline requesters.
// A request is only granted while a memory-network credit is free and the
// one-entry output register is empty or draining this cycle.
//
// Ports
//   gclk        : clock
//   rst         : synchronous active-high reset
//   req_valid   : per-requester request valid
//   req_data    : per-requester payload
//   req_ready   : one-hot grant (combinational, includes mem_ready)
//   mem_valid   : output register holds a request
//   mem_data    : payload of the held request
//   mem_src     : requester index of the held request
//   mem_ready   : memory port takes the held request this cycle
//   credit_ret  : one credit returned this cycle
//   credit_cnt  : free credits
//   credit_err  : sticky, credit returned while the pool was already full
//   stall_cnt   : cycles spent with a request pending and no credit
//
// Optional feature macro: MEMCREDIT_STAT_EN enables the saturating
// stall_cnt counter; without it stall_cnt is constant zero.
// ---------------------------------------------------------------------------
module mem_credit_arb
   import mem_credit_arb_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int DW        = 64,
   parameter int MAXCREDIT = MAXMEMCREDIT,
   parameter int CW        = MAXMEMCREDITMSB + 1,
   parameter int SW        = log2x(NREQ)
) (
   input  logic                     gclk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ-1:0][DW-1:0]  req_data,
   output logic [NREQ-1:0]          req_ready,
   output logic                     mem_valid,
   output logic [DW-1:0]            mem_data,
   output logic [SW-1:0]            mem_src,
   input  logic                     mem_ready,
   input  logic                     credit_ret,
   output logic [CW-1:0]            credit_cnt,
   output logic                     credit_err,
   output logic [31:0]              stall_cnt
);

   logic [NREQ-1:0] w_grant;
   logic [SW-1:0]   w_idx;
   logic            w_any;
   logic            w_issue_ok;
   logic            w_accept;
   logic [SW-1:0]   w_rr_next;
   logic [CW-1:0]   w_credit_next;
   logic            w_credit_ovf;

   logic            r_mem_valid;
   logic [DW-1:0]   r_mem_data;
   logic [SW-1:0]   r_mem_src;
   logic [SW-1:0]   r_rr_ptr;
   logic [CW-1:0]   r_credit_cnt;
   logic            r_credit_err;

   rr_arbiter #(
      .NREQ (NREQ),
      .SW   (SW)
   ) u_rr_arbiter (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // rst gates the grant so no handshake is seen while registers are still
   // being initialised.
   assign w_issue_ok = !rst && (r_credit_cnt != '0) && (!r_mem_valid || mem_ready);
   assign w_accept   = w_issue_ok && w_any;
   assign req_ready  = w_issue_ok ? w_grant : '0;

   assign w_rr_next  = (w_idx == SW'(NREQ - 1)) ? '0 : w_idx + SW'(1);

   // A simultaneous accept and return cancel out; a return into a full pool
   // is discarded and flagged.
   always_comb begin
      w_credit_next = r_credit_cnt;
      w_credit_ovf  = 1'b0;
      if (w_accept && !credit_ret) begin
         w_credit_next = r_credit_cnt - CW'(1);
      end else if (!w_accept && credit_ret) begin
         if (r_credit_cnt == CW'(MAXCREDIT)) begin
            w_credit_ovf = 1'b1;
         end else begin
            w_credit_next = r_credit_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge gclk) begin
      if (rst) begin
         r_mem_valid  <= 1'b0;
         r_mem_data   <= '0;
         r_mem_src    <= '0;
         r_rr_ptr     <= '0;
         r_credit_cnt <= CW'(MAXCREDIT);
         r_credit_err <= 1'b0;
      end else begin
         if (w_accept) begin
            r_mem_valid <= 1'b1;
            r_mem_data  <= req_data[w_idx];
            r_mem_src   <= w_idx;
            r_rr_ptr    <= w_rr_next;
         end else if (mem_ready) begin
            r_mem_valid <= 1'b0;
         end
         r_credit_cnt <= w_credit_next;
         if (w_credit_ovf) begin
            r_credit_err <= 1'b1;
         end
      end
   end

   assign mem_valid  = r_mem_valid;
   assign mem_data   = r_mem_data;
   assign mem_src    = r_mem_src;
   assign credit_cnt = r_credit_cnt;
   assign credit_err = r_credit_err;

`ifdef MEMCREDIT_STAT_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge gclk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (|req_valid && (r_credit_cnt == '0) && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: doc/mem_credit_arb.md
# mem_credit_arb

Credit-based arbiter sharing the single memory-controller port among NREQ pipeline requesters. Holds a pool of memory-network credits (one per outstanding request), grants at most one request per cycle round-robin when a credit is available, and latches the winner into a one-entry output register toward the memory network. Credits come back from the memory side as responses retire. The block sits between the pipelines' memory-request stages and the memory-controller port.

## Interface
- NREQ, 4: number of requesters (2..16)
- DW, 64: request payload width
- MAXCREDIT, MAXMEMCREDIT (64): credit pool size
- CW, MAXMEMCREDITMSB+1: credit counter width (holds 0..MAXCREDIT)

- gclk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester request valid
- req_data  in  NREQ x DW  per-requester payload
- req_ready  out  NREQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i]
- mem_valid  out  1  output register holds a request
- mem_data  out  DW  payload of held request
- mem_src  out  log2x(NREQ)  index of the requester that issued the held request
- mem_ready  in  1  memory port accepts the held request this cycle
- credit_ret  in  1  one credit returned this cycle
- credit_cnt  out  CW  current free credits
- credit_err  out  1  sticky: credit returned while pool full
- stall_cnt  out  32  credit-starvation cycle counter (see Configuration)

## Operation
- issue_ok = (credit_cnt != 0) && (!mem_valid || mem_ready).
- When issue_ok, rr_arbiter picks the first valid requester at or after rr_ptr (wrapping NREQ-1 -> 0); its req_ready bit is 1, all others 0. When !issue_ok, req_ready = 0.
- On acceptance: output register loads req_data/index, mem_valid=1; rr_ptr = winner+1 mod NREQ; one credit consumed.
- If mem_ready && mem_valid with no new acceptance, mem_valid -> 0.
- Credit update per cycle: next = cnt - accept + credit_ret. Accept and return in the same cycle: count unchanged.
- credit_ret when cnt == MAXCREDIT and no accept: count stays MAXCREDIT, credit_err set (cleared only by rst).
- No requester valid: rr_ptr unchanged.
- Reset mid-operation: held request dropped (no mem_valid), outstanding credits forgotten; pool restored to MAXCREDIT. Memory side must be reset together.

## Timing
- Reset values: mem_valid=0, mem_data=0, mem_src=0, credit_cnt=MAXCREDIT, credit_err=0, stall_cnt=0, rr_ptr=0; req_ready=0 while rst asserted.
- req_ready combinational from req_valid and registered state; no combinational path from mem_ready to mem_valid; mem_ready -> req_ready is combinational (throughput 1 request/cycle).
- Accept in cycle t -> mem_valid/mem_data at t+1 (latency 1).
- credit_cnt registered: a credit returned in cycle t is usable for an issue in t+1.
- mem_data/mem_src stable while mem_valid && !mem_ready.

## Configuration
- MEMCREDIT_STAT_EN defined: stall_cnt increments (saturating at 2^32-1) every cycle with |req_valid && credit_cnt == 0; reset to 0.
- Not defined: stall_cnt tied to 0, no counter logic.

## Structure
- libconf gains typedef bit [MAXMEMCREDITMSB:0] mem_credit_t; MAXMEMCREDIT/MAXMEMCREDITMSB stay in libconf.
- Sub-module rr_arbiter: NREQ-wide request vector + pointer -> one-hot grant and encoded index, purely combinational.

## Test plan
- Reset release, all 4 requesters valid, mem_ready=1 constantly -> grants 0,1,2,3,0 on consecutive cycles; credit_cnt 64,63,62,61,60.
- 64 accepts, no credit_ret -> credit_cnt=0, req_ready=0 from then; one credit_ret -> exactly one grant next cycle.
- mem_ready=0 for 5 cycles with mem_valid=1 -> mem_data/mem_src stable, req_ready=0, credit_cnt unchanged.
- Accept and credit_ret in same cycle at credit_cnt=10 -> credit_cnt stays 10.
- credit_ret at credit_cnt=64 -> credit_cnt=64, credit_err=1 until rst.
- With MEMCREDIT_STAT_EN: pool exhausted, requester 2 valid for 7 cycles -> stall_cnt=7; without macro -> stall_cnt=0.
